// File: rtl/sum_it_up_pkg.sv
// Shared types and default parameters for the sum_it_up accumulator family.
package sum_it_up_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_SUM_W     = 12;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_MAX_TERMS = 200;
  localparam bit DEF_SATURATE  = 1'b0;

endpackage

// File: rtl/sat_adder.sv
// Combinational adder of a SUM_W accumulator and a WIDTH term, with carry-out
// and optional clamp-to-all-ones on overflow.
module sat_adder
  import sum_it_up_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int SUM_W    = DEF_SUM_W,
  parameter bit SATURATE = DEF_SATURATE
) (
  input  logic [SUM_W-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [SUM_W-1:0] result,
  output logic             carry
);

  logic [SUM_W:0] full_s;

  always_comb begin
    full_s = {1'b0, a} + {{(SUM_W + 1 - WIDTH){1'b0}}, b};
    carry  = full_s[SUM_W];
    if (SATURATE && full_s[SUM_W]) begin
      result = '1;
    end else begin
      result = full_s[SUM_W-1:0];
    end
  end

endmodule

// File: rtl/sum_it_up_n.sv
// Zero-terminated stream accumulator with term limit, sticky overflow and a
// result held until the consumer acknowledges.
module sum_it_up_n
  import sum_it_up_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SUM_W     = DEF_SUM_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int MAX_TERMS = DEF_MAX_TERMS,
  parameter bit SATURATE  = DEF_SATURATE
) (
  input  logic             ck,
  input  logic             reset_l,
  input  logic             go_l,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] inA,
  output logic             in_ready,
  input  logic             ack,
  output logic             done,
  output logic [SUM_W-1:0] sum,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             limit
);

  if (SUM_W < WIDTH) begin : g_bad_sum_w
    $error("sum_it_up_n: SUM_W must be >= WIDTH");
  end
  if (MAX_TERMS < 1 || MAX_TERMS > (2 ** CNT_W) - 1) begin : g_bad_max_terms
    $error("sum_it_up_n: MAX_TERMS out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

  state_e           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             limit_q, limit_d;

  logic [SUM_W-1:0] add_res_s;
  logic             add_carry_s;
  logic [CNT_W-1:0] cnt_inc_s;

  sat_adder #(
    .WIDTH   (WIDTH),
    .SUM_W   (SUM_W),
    .SATURATE(SATURATE)
  ) u_add (
    .a     (sum_q),
    .b     (inA),
    .result(add_res_s),
    .carry (add_carry_s)
  );

  assign cnt_inc_s = count_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    limit_d = limit_q;
    case (state_q)
      IDLE: begin
        if (!go_l) begin
          sum_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          limit_d = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        // in_ready is exactly (state == ACCUM), so in_valid alone marks a transfer
        if (in_valid) begin
          if (inA == '0) begin
            state_d = DONE;
          end else begin
            sum_d   = add_res_s;
            ovf_d   = ovf_q | add_carry_s;
            count_d = cnt_inc_s;
            if (cnt_inc_s == MAX_CNT) begin
              limit_d = 1'b1;
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        if (ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    done_d = (state_d == DONE);
  end

  always_ff @(posedge ck or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= IDLE;
      sum_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      limit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      limit_q <= limit_d;
    end
  end

  assign in_ready = (state_q == ACCUM);
  assign done     = done_q;
  assign sum      = sum_q;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign limit    = limit_q;

endmodule

// File: tb/tb_sum_it_up_n.sv
// Bench for sum_it_up_n: four configurations share one stimulus bus; a model
// pushes expected results to a queue that is popped when done rises.
module tb_sum_it_up_n;

  typedef struct {
    int sum;
    int cnt;
    bit ovf;
    bit lim;
  } exp_t;

  // Per-instance config: 0 default, 1 wrap (8b), 2 saturate (8b), 3 limit 3
  int sw_t [4] = '{12, 8, 8, 12};
  bit sat_t[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  int mt_t [4] = '{200, 200, 200, 3};

  logic       ck = 1'b0;
  logic       reset_l = 1'b0;
  logic       go_l = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] inA = 8'd0;
  logic       ack = 1'b0;

  logic [3:0]  rdy, dn, ovf, lim;
  logic [7:0]  cnt_v [4];
  logic [11:0] sum0, sum3;
  logic [7:0]  sum1, sum2;
  logic [11:0] sum_v [4];

  int   checks = 0;
  int   passed = 0;
  int   stim_q[$];
  exp_t exp_q[$];

  always #5 ck = ~ck;

  assign sum_v[0] = sum0;
  assign sum_v[1] = {4'd0, sum1};
  assign sum_v[2] = {4'd0, sum2};
  assign sum_v[3] = sum3;

  sum_it_up_n u_def (
    .ck(ck), .reset_l(reset_l), .go_l(go_l), .in_valid(in_valid), .inA(inA),
    .in_ready(rdy[0]), .ack(ack), .done(dn[0]), .sum(sum0), .count(cnt_v[0]),
    .overflow(ovf[0]), .limit(lim[0]));

  sum_it_up_n #(.SUM_W(8), .SATURATE(1'b0)) u_wrap (
    .ck(ck), .reset_l(reset_l), .go_l(go_l), .in_valid(in_valid), .inA(inA),
    .in_ready(rdy[1]), .ack(ack), .done(dn[1]), .sum(sum1), .count(cnt_v[1]),
    .overflow(ovf[1]), .limit(lim[1]));

  sum_it_up_n #(.SUM_W(8), .SATURATE(1'b1)) u_sat (
    .ck(ck), .reset_l(reset_l), .go_l(go_l), .in_valid(in_valid), .inA(inA),
    .in_ready(rdy[2]), .ack(ack), .done(dn[2]), .sum(sum2), .count(cnt_v[2]),
    .overflow(ovf[2]), .limit(lim[2]));

  sum_it_up_n #(.MAX_TERMS(3)) u_lim (
    .ck(ck), .reset_l(reset_l), .go_l(go_l), .in_valid(in_valid), .inA(inA),
    .in_ready(rdy[3]), .ack(ack), .done(dn[3]), .sum(sum3), .count(cnt_v[3]),
    .overflow(ovf[3]), .limit(lim[3]));

  function automatic exp_t model(int idx);
    exp_t e;
    int   mask = (1 << sw_t[idx]) - 1;
    int   full;
    e = '{0, 0, 1'b0, 1'b0};
    for (int k = 0; k < stim_q.size(); k++) begin
      if (stim_q[k] < 0) continue;
      if (stim_q[k] == 0) break;
      full = e.sum + stim_q[k];
      if (full > mask) begin
        e.ovf = 1'b1;
        e.sum = sat_t[idx] ? mask : (full & mask);
      end else begin
        e.sum = full;
      end
      e.cnt++;
      if (e.cnt == mt_t[idx]) begin
        e.lim = 1'b1;
        break;
      end
    end
    return e;
  endfunction

  function automatic logic [21:0] got_of(int idx);
    return {sum_v[idx], cnt_v[idx], ovf[idx], lim[idx]};
  endfunction

  function automatic logic [21:0] want_of(exp_t e);
    return {12'(e.sum), 8'(e.cnt), e.ovf, e.lim};
  endfunction

  task automatic do_reset();
    @(negedge ck);
    reset_l = 1'b0; go_l = 1'b1; in_valid = 1'b0; inA = 8'd0; ack = 1'b0;
    @(negedge ck);
    reset_l = 1'b1;
  endtask

  // Go pulse, then one stim entry per cycle; -1 is a gap cycle with junk data.
  task automatic drive_run(input int idx);
    exp_q.push_back(model(idx));
    @(negedge ck);
    go_l = 1'b0;
    @(negedge ck);
    go_l = 1'b1;
    for (int k = 0; k < stim_q.size(); k++) begin
      if (stim_q[k] < 0) begin
        in_valid = 1'b0; inA = 8'd77;
      end else begin
        in_valid = 1'b1; inA = 8'(stim_q[k]);
      end
      @(negedge ck);
    end
    in_valid = 1'b0; inA = 8'd0;
  endtask

  task automatic wait_done(input int idx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dn[idx]) begin
        ok = 1'b1;
        break;
      end
      @(negedge ck);
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge ck);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_l = 1'b0;
    repeat (2) @(negedge ck);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({got_of(i), dn[i], rdy[i]} !== 24'd0)
        $display("FAIL reset_state[%0d] got %h want 0", i, {got_of(i), dn[i], rdy[i]});
      else passed++;
    end
    reset_l = 1'b1;
  endtask

  task automatic test_basic();
    bit   ok;
    exp_t e;
    do_reset();
    stim_q = '{5, 7, 3, 0};
    drive_run(0);
    wait_done(0, ok);
    checks++;
    if (!ok) $display("FAIL basic_done got 0 want 1"); else passed++;
    e = exp_q.pop_front();
    checks++;
    if (got_of(0) !== want_of(e))
      $display("FAIL basic_result got %h want %h", got_of(0), want_of(e));
    else passed++;
    // go_l is ignored in DONE; hold it low along with ack low
    go_l = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ck);
      checks++;
      if ({got_of(0), dn[0], rdy[0]} !== {want_of(e), 1'b1, 1'b0})
        $display("FAIL basic_hold[%0d] got %h want %h", i,
                 {got_of(0), dn[0], rdy[0]}, {want_of(e), 1'b1, 1'b0});
      else passed++;
    end
    do_ack();
    checks++;
    if ({dn[0], rdy[0], sum_v[0]} !== {1'b0, 1'b0, 12'd15})
      $display("FAIL basic_ack got %h want %h", {dn[0], rdy[0], sum_v[0]}, {1'b0, 1'b0, 12'd15});
    else passed++;
    @(negedge ck);
    checks++;
    if ({rdy[0], sum_v[0], cnt_v[0]} !== {1'b1, 12'd0, 8'd0})
      $display("FAIL basic_restart got %h want %h", {rdy[0], sum_v[0], cnt_v[0]}, {1'b1, 12'd0, 8'd0});
    else passed++;
    go_l = 1'b1;
  endtask

  task automatic test_wrap();
    bit   ok;
    exp_t e;
    do_reset();
    stim_q = '{200, 100, 0};
    drive_run(1);
    wait_done(1, ok);
    checks++;
    if (!ok) $display("FAIL wrap_done got 0 want 1"); else passed++;
    e = exp_q.pop_front();
    checks++;
    if (got_of(1) !== want_of(e))
      $display("FAIL wrap_result got %h want %h", got_of(1), want_of(e));
    else passed++;
  endtask

  task automatic test_saturate();
    bit   ok;
    exp_t e;
    do_reset();
    stim_q = '{200, 100, 5, 0};
    drive_run(2);
    wait_done(2, ok);
    checks++;
    if (!ok) $display("FAIL sat_done got 0 want 1"); else passed++;
    e = exp_q.pop_front();
    checks++;
    if (got_of(2) !== want_of(e))
      $display("FAIL sat_result got %h want %h", got_of(2), want_of(e));
    else passed++;
  endtask

  task automatic test_limit();
    exp_t e;
    do_reset();
    stim_q = '{1, 2, 3};
    drive_run(3);
    checks++;
    if ({dn[3], rdy[3]} !== 2'b10)
      $display("FAIL limit_latency got %b want 10", {dn[3], rdy[3]});
    else passed++;
    e = exp_q.pop_front();
    checks++;
    if (got_of(3) !== want_of(e))
      $display("FAIL limit_result got %h want %h", got_of(3), want_of(e));
    else passed++;
    in_valid = 1'b1; inA = 8'd9;
    @(negedge ck);
    in_valid = 1'b0; inA = 8'd0;
    checks++;
    if ({got_of(3), dn[3], rdy[3]} !== {want_of(e), 1'b1, 1'b0})
      $display("FAIL limit_extra got %h want %h", {got_of(3), dn[3], rdy[3]}, {want_of(e), 1'b1, 1'b0});
    else passed++;
  endtask

  task automatic test_gaps();
    bit   ok;
    exp_t e;
    do_reset();
    stim_q = '{4, -1, 4, 0};
    drive_run(0);
    wait_done(0, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || got_of(0) !== want_of(e))
      $display("FAIL gaps_result got %h want %h", got_of(0), want_of(e));
    else passed++;
    do_ack();
    in_valid = 1'b1; inA = 8'd50;
    repeat (3) @(negedge ck);
    in_valid = 1'b0; inA = 8'd0;
    checks++;
    if ({got_of(0), dn[0], rdy[0]} !== {want_of(e), 1'b0, 1'b0})
      $display("FAIL idle_input got %h want %h", {got_of(0), dn[0], rdy[0]}, {want_of(e), 1'b0, 1'b0});
    else passed++;
    stim_q = '{0};
    drive_run(0);
    wait_done(0, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || got_of(0) !== want_of(e))
      $display("FAIL immediate_term got %h want %h", got_of(0), want_of(e));
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit   ok;
    exp_t e;
    do_reset();
    @(negedge ck);
    go_l = 1'b0;
    @(negedge ck);
    go_l = 1'b1; in_valid = 1'b1; inA = 8'd200;
    @(negedge ck);
    inA = 8'd100;
    @(negedge ck);
    in_valid = 1'b0; inA = 8'd0;
    checks++;
    if ({sum_v[1], cnt_v[1], ovf[1], rdy[1]} !== {12'd44, 8'd2, 1'b1, 1'b1})
      $display("FAIL midrun_pre got %h want %h", {sum_v[1], cnt_v[1], ovf[1], rdy[1]}, {12'd44, 8'd2, 1'b1, 1'b1});
    else passed++;
    #2 reset_l = 1'b0;
    #1;
    checks++;
    if ({got_of(1), dn[1], rdy[1]} !== 24'd0)
      $display("FAIL midrun_reset got %h want 0", {got_of(1), dn[1], rdy[1]});
    else passed++;
    #1 reset_l = 1'b1;
    stim_q = '{2, 0};
    drive_run(1);
    wait_done(1, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || got_of(1) !== want_of(e))
      $display("FAIL midrun_next got %h want %h", got_of(1), want_of(e));
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_saturate();
    test_limit();
    test_gaps();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
